// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the instruction memory. Receives the program as a
//   byte stream (valid/ready), packs big-endian 32-bit words and writes them
//   to consecutive word addresses from BASE_ADDR. The processor is held off
//   (cpu_hold) until the all-zero terminator word has been stored.
//
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready.
//   byte_ready is a registered output and never depends on byte_valid. The
//   source may hold byte_valid low for any length of time without losing
//   state, and must keep byte_in stable until the byte is taken.
//
// Ports
//   clock       system clock, rising edge
//   reset       synchronous, active-high, overrides every other input
//   byte_in     program byte
//   byte_valid  byte_in is valid
//   byte_ready  loader takes a byte this cycle (RECV state only)
//   imem_we     one-cycle instruction-memory write strobe per word
//   imem_addr   write byte address = BASE_ADDR + 4*word_count
//   imem_wdata  assembled word
//   cpu_hold    keep the processor stalled
//   done        program and terminator stored
//   overflow    memory full before a terminator arrived
//   word_count  words written so far
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0040_0000,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        overflow,
  output logic [15:0] word_count
);

  typedef enum logic [1:0] {
    S_RECV  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [15:0] DEPTH_LIM = 16'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  // Holds bytes 0..2 of the current word; byte 3 goes straight into wdata.
  logic [23:0] buf_q, buf_d;
  logic [15:0] count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        ready_q, ready_d;
  logic        hold_q, hold_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    ready_d = ready_q;
    hold_d  = hold_q;
    done_d  = done_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_RECV: begin
        if (byte_valid && ready_q) begin
          if (idx_q == 2'd3) begin
            // Last byte: launch the write with the whole word registered so
            // addr/wdata are stable for the entire strobe cycle.
            wdata_d = {buf_q, byte_in};
            we_d    = 1'b1;
            ready_d = 1'b0;
            idx_d   = 2'd0;
            state_d = S_WRITE;
          end else begin
            buf_d = {buf_q[15:0], byte_in};
            idx_d = idx_q + 2'd1;
          end
        end
      end

      S_WRITE: begin
        we_d    = 1'b0;
        count_d = count_q + 16'd1;
        addr_d  = BASE_ADDR + {14'd0, count_d, 2'b00};
        if (wdata_q == 32'd0) begin
          // Terminator has priority over the full check: it may occupy the
          // last slot.
          state_d = S_DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
          ready_d = 1'b0;
        end else if (count_d == DEPTH_LIM) begin
          state_d = S_ERROR;
          ovf_d   = 1'b1;
          hold_d  = 1'b1;
          ready_d = 1'b0;
        end else begin
          state_d = S_RECV;
          ready_d = 1'b1;
        end
      end

      S_DONE, S_ERROR: begin
        // Terminal until reset; inputs are ignored.
      end

      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_RECV;
      idx_q   <= 2'd0;
      buf_q   <= 24'd0;
      count_q <= 16'd0;
      addr_q  <= BASE_ADDR;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign byte_ready = ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Directed bench for imem_loader. Two instances share the stimulus: m_*
//   uses the default depth, o_* uses DEPTH_WORDS=4 for the overflow case.
//   Writes of the main instance are checked against an expected queue of
//   {addr, data} pairs; writes of the small instance are logged.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;

  logic        m_byte_ready, m_imem_we, m_cpu_hold, m_done, m_overflow;
  logic [31:0] m_imem_addr, m_imem_wdata;
  logic [15:0] m_word_count;

  logic        o_byte_ready, o_imem_we, o_cpu_hold, o_done, o_overflow;
  logic [31:0] o_imem_addr, o_imem_wdata;
  logic [15:0] o_word_count;

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(256)) dut (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(m_byte_ready), .imem_we(m_imem_we), .imem_addr(m_imem_addr),
    .imem_wdata(m_imem_wdata), .cpu_hold(m_cpu_hold), .done(m_done),
    .overflow(m_overflow), .word_count(m_word_count)
  );

  imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(4)) dut_ovf (
    .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(o_byte_ready), .imem_we(o_imem_we), .imem_addr(o_imem_addr),
    .imem_wdata(o_imem_wdata), .cpu_hold(o_cpu_hold), .done(o_done),
    .overflow(o_overflow), .word_count(o_word_count)
  );

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic [63:0] exp_q[$];
  logic [63:0] ovf_log[$];
  int          we_cyc_q[$];
  int          acc_cyc_q[$];
  int          m_we_cnt = 0;
  int          done_cyc;
  logic [63:0] exp_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (m_imem_we) begin
      m_we_cnt++;
      we_cyc_q.push_back(cyc);
      if (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        check("wr_addr", m_imem_addr, exp_e[63:32]);
        check("wr_data", m_imem_wdata, exp_e[31:0]);
      end else begin
        check("spurious_we", {31'b0, m_imem_we}, 32'd0);
      end
    end
    if (o_imem_we) ovf_log.push_back({o_imem_addr, o_imem_wdata});
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    byte_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    ovf_log.delete();
    we_cyc_q.delete();
    acc_cyc_q.delete();
  endtask

  task automatic expect_wr(input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Presents a byte after 'gap' idle cycles and holds it until taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    if (gap > 0) begin
      byte_valid = 1'b0;
      repeat (gap) @(posedge clock);
      #1;
    end
    byte_in    = b;
    byte_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clock);
      acc = m_byte_ready;
      @(posedge clock);
      #1;
    end
    if (!acc) check("accept_timeout", {31'b0, m_byte_ready}, 32'd1);
    else acc_cyc_q.push_back(cyc);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
  endtask

  task automatic send_word_rand(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], $urandom_range(0, 5));
  endtask

  task automatic wait_done();
    logic seen;
    byte_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (m_done) begin
        seen     = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) check("done_timeout", {31'b0, m_done}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic basic_load();
    expect_wr(BASE, 32'h2008_0005);
    expect_wr(BASE + 32'd4, 32'h0000_0000);
    send_word(32'h2008_0005, 0);
    send_word(32'h0000_0000, 0);
    wait_done();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int we_before;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    // Reset values while reset is still held.
    check("rst_ready", {31'b0, m_byte_ready}, 32'd1);
    check("rst_we",    {31'b0, m_imem_we}, 32'd0);
    check("rst_addr",  m_imem_addr, BASE);
    check("rst_wdata", m_imem_wdata, 32'd0);
    check("rst_hold",  {31'b0, m_cpu_hold}, 32'd1);
    check("rst_done",  {31'b0, m_done}, 32'd0);
    check("rst_ovf",   {31'b0, m_overflow}, 32'd0);
    check("rst_count", {16'b0, m_word_count}, 32'd0);
    // Byte offered while reset is high must not be taken.
    byte_in    = 8'hAA;
    byte_valid = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    byte_valid = 1'b0;

    // Basic load.
    we_before = m_we_cnt;
    basic_load();
    check("basic_done",  {31'b0, m_done}, 32'd1);
    check("basic_hold",  {31'b0, m_cpu_hold}, 32'd0);
    check("basic_count", {16'b0, m_word_count}, 32'd2);
    check("basic_we_n",  32'(m_we_cnt - we_before), 32'd2);
    check("basic_left",  32'(exp_q.size()), 32'd0);

    // Post-done lockout.
    we_before = m_we_cnt;
    for (int i = 0; i < 20; i++) begin
      byte_in    = 8'($urandom_range(0, 255));
      byte_valid = 1'b1;
      @(posedge clock);
      #1;
    end
    byte_valid = 1'b0;
    check("lock_ready", {31'b0, m_byte_ready}, 32'd0);
    check("lock_we_n",  32'(m_we_cnt - we_before), 32'd0);
    check("lock_count", {16'b0, m_word_count}, 32'd2);
    check("lock_done",  {31'b0, m_done}, 32'd1);

    // After reset a new load starts at the base again.
    do_reset();
    basic_load();
    check("reload_count", {16'b0, m_word_count}, 32'd2);
    check("reload_left",  32'(exp_q.size()), 32'd0);

    // Stalled source; first byte of word 2 is offered during the WRITE cycle.
    do_reset();
    expect_wr(BASE, 32'h2008_0005);
    expect_wr(BASE + 32'd4, 32'h0000_0000);
    send_word_rand(32'h2008_0005);
    check("stall_we_in_write",    {31'b0, m_imem_we}, 32'd1);
    check("stall_ready_in_write", {31'b0, m_byte_ready}, 32'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, $urandom_range(0, 5));
    send_byte(8'h00, $urandom_range(0, 5));
    send_byte(8'h00, $urandom_range(0, 5));
    wait_done();
    check("stall_count", {16'b0, m_word_count}, 32'd2);
    check("stall_left",  32'(exp_q.size()), 32'd0);

    // Reset mid-word: partial 8C 01 is discarded.
    do_reset();
    send_byte(8'h8C, 0);
    send_byte(8'h01, 0);
    do_reset();
    expect_wr(BASE, 32'h0022_0820);
    expect_wr(BASE + 32'd4, 32'h0000_0000);
    send_word(32'h0022_0820, 0);
    send_word(32'h0000_0000, 0);
    wait_done();
    check("midrst_count", {16'b0, m_word_count}, 32'd2);
    check("midrst_left",  32'(exp_q.size()), 32'd0);

    // Overflow on the 4-deep instance.
    do_reset();
    expect_wr(BASE,          32'h1111_1111);
    expect_wr(BASE + 32'd4,  32'h2222_2222);
    expect_wr(BASE + 32'd8,  32'h3333_3333);
    expect_wr(BASE + 32'd12, 32'h4444_4444);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_word(32'h3333_3333, 0);
    send_word(32'h4444_4444, 0);
    byte_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("ovf_writes", 32'(ovf_log.size()), 32'd4);
    if (ovf_log.size() == 4) begin
      check("ovf_a0", ovf_log[0][63:32], 32'h0040_0000);
      check("ovf_a3", ovf_log[3][63:32], 32'h0040_000C);
      check("ovf_d3", ovf_log[3][31:0],  32'h4444_4444);
    end
    check("ovf_flag",  {31'b0, o_overflow}, 32'd1);
    check("ovf_hold",  {31'b0, o_cpu_hold}, 32'd1);
    check("ovf_ready", {31'b0, o_byte_ready}, 32'd0);
    check("ovf_done",  {31'b0, o_done}, 32'd0);
    check("ovf_count", {16'b0, o_word_count}, 32'd4);
    check("ovf_main_ready", {31'b0, m_byte_ready}, 32'd1);
    check("ovf_main_flag",  {31'b0, m_overflow}, 32'd0);
    check("ovf_main_left",  32'(exp_q.size()), 32'd0);

    // Back-to-back: 3 words + terminator with byte_valid held high.
    do_reset();
    expect_wr(BASE,          32'h0123_4567);
    expect_wr(BASE + 32'd4,  32'h89AB_CDEF);
    expect_wr(BASE + 32'd8,  32'hFFFF_FFFF);
    expect_wr(BASE + 32'd12, 32'h0000_0000);
    send_word(32'h0123_4567, 0);
    send_word(32'h89AB_CDEF, 0);
    send_word(32'hFFFF_FFFF, 0);
    send_word(32'h0000_0000, 0);
    wait_done();
    check("b2b_we_n", 32'(we_cyc_q.size()), 32'd4);
    if (we_cyc_q.size() == 4) begin
      check("b2b_gap1", 32'(we_cyc_q[1] - we_cyc_q[0]), 32'd5);
      check("b2b_gap2", 32'(we_cyc_q[2] - we_cyc_q[1]), 32'd5);
      check("b2b_gap3", 32'(we_cyc_q[3] - we_cyc_q[2]), 32'd5);
    end
    // done rises at the edge ending cycle 20, counting the first accept
    // cycle as cycle 1 (4 words x 5 cycles).
    if (acc_cyc_q.size() > 0)
      check("b2b_done_lat", 32'(done_cyc - acc_cyc_q[0] + 1), 32'd20);
    check("b2b_count", {16'b0, m_word_count}, 32'd4);
    // Terminator in the last slot of the 4-deep instance is not an overflow.
    check("b2b_small_done", {31'b0, o_done}, 32'd1);
    check("b2b_small_ovf",  {31'b0, o_overflow}, 32'd0);
    check("b2b_left", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit MIPS words, and writes them to consecutive instruction-memory addresses starting at the text-segment base. It sits in front of `instruction_memory`'s write port and holds the processor off (`cpu_hold`) until the program, terminated by an all-zero word (the processor's halt instruction), has been fully stored.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h00400000: byte address of the first word written.
- `DEPTH_WORDS`, default 256: instruction-memory capacity in words, including the terminator.

Ports:
- `clock`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  synchronous, active-high; has priority over every other input.
- `byte_in`  input  8  incoming program byte.
- `byte_valid`  input  1  `byte_in` is valid.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `imem_we`  output  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  output  32  write byte address: `BASE_ADDR + 4*word_count`.
- `imem_wdata`  output  32  assembled word.
- `cpu_hold`  output  1  keep the PC and processor stalled or in reset.
- `done`  output  1  program loaded and terminator written.
- `overflow`  output  1  memory filled before a terminator arrived.
- `word_count`  output  16  number of words written so far.

## Operation
- States: RECV, WRITE, DONE, ERROR. Reset enters RECV.
- Reset values: `byte_ready`=1, `imem_we`=0, `imem_addr`=`BASE_ADDR`, `imem_wdata`=0, `cpu_hold`=1, `done`=0, `overflow`=0, `word_count`=0, byte index=0.
- Byte transfer: a byte is accepted on a rising edge where `byte_valid && byte_ready`. `byte_ready` is 1 only in RECV.
- Byte packing is big-endian. Byte index 0 goes to bits 31:24, index 1 to 23:16, index 2 to 15:8, and index 3 to 7:0. The index increments per accepted byte.
- Accepting byte index 3 moves the block RECV→WRITE and resets the index to 0.
- WRITE lasts exactly one cycle:
  - `imem_we`=1; `imem_addr` and `imem_wdata` are stable for the whole cycle.
  - At the next edge, `word_count` increments.
  - If the word was 0x00000000 → DONE.
  - Else if the new `word_count` == `DEPTH_WORDS` → ERROR, because no slot remains for the terminator.
  - Else → RECV.
- DONE: `done`=1, `cpu_hold`=0, `byte_ready`=0. Input bytes are ignored. The block stays in DONE until reset.
- ERROR: `overflow`=1, `cpu_hold`=1, `byte_ready`=0. The block stays in ERROR until reset.
- `imem_addr` tracks `word_count` at all times. Arithmetic is 32-bit modulo; the bench must not configure a wrap.
- Reset in any state, including mid-word or during WRITE: partial bytes are discarded, any pending write is suppressed, and all outputs return to their reset values on that edge.
- `byte_valid` deasserted in RECV: the block holds state; no timeout.

## Timing
- Outputs are registered, or decoded from registered state only. There are no combinational input→output paths, so `byte_ready` does not depend on `byte_valid`.
- If the 4th byte of a word is accepted at edge N:
  - `imem_we` is high from N to N+1, and memory captures the word at edge N+1.
  - `word_count` updates at N+1.
  - `byte_ready` is low from N to N+1 and high again from N+1 unless the next state is DONE or ERROR.
- Peak throughput: 1 word per 5 cycles (4 accept cycles + 1 write cycle).
- `done` and the `cpu_hold` release rise at the edge that ends the terminator's WRITE cycle.
- Reset: outputs show reset values in the cycle after the edge that samples `reset`=1. With reset held, `byte_ready` remains 1, but nothing is accepted while `reset`=1.

## Test plan
- Basic load: after reset, send 20 08 00 05 then 00 00 00 00. Required:
  - write 0x20080005 @0x00400000;
  - write 0x00000000 @0x00400004;
  - `done`=1, `cpu_hold`=0, `word_count`=2, exactly two `imem_we` pulses.
- Stalled source: the same stream with `byte_valid` deasserted for random 0-5 cycle gaps → identical writes. A byte presented during WRITE is not consumed and is taken on the following RECV cycle.
- Reset mid-word: send 8C 01, pulse `reset`, then send 00 22 08 20 00 00 00 00. Required: first write 0x00220820 @0x00400000; no write containing 0x8C01.
- Overflow with `DEPTH_WORDS`=4: send four nonzero words. Required: four writes @0x00400000-0x0040000C, then `overflow`=1, `cpu_hold`=1, `byte_ready`=0, `done`=0.
- Post-done lockout: after a basic load, drive `byte_valid`=1 with arbitrary bytes for 20 cycles. Required: `byte_ready`=0, no `imem_we`, `word_count` unchanged. After reset, a new load again starts at 0x00400000.
- Back-to-back: `byte_valid` held at 1, 3 nonzero words plus terminator. Required: `imem_we` pulses exactly 5 cycles apart; `done` rises 20 cycles after the first byte is accepted.
